// File: rtl/mem_dma_pkg.sv
// Shared definitions for the mem_dma copy/fill engine and its CPU-side wrapper.
package mem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam logic [3:0] WSTRB_NONE = 4'h0;

  // Byte offsets of the control registers exposed by the CPU wrapper.
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_SRC    = 8'h04;
  localparam logic [7:0] REG_DST    = 8'h08;
  localparam logic [7:0] REG_LEN    = 8'h0C;
  localparam logic [7:0] REG_FILL   = 8'h10;
  localparam logic [7:0] REG_STATUS = 8'h14;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Word-granular memory copy/fill engine; initiator on the picorv32 native bus.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] word_count,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             mem_valid,
  output logic             mem_instr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata
);

  dma_state_t       state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] cnt_q;
  logic             mode_q;

  logic [31:0] src_nxt;
  logic [31:0] dst_nxt;
  logic        last_word;

  assign src_nxt   = src_q + 32'd4;
  assign dst_nxt   = dst_q + 32'd4;
  assign last_word = (cnt_q == LEN_W'(1));
  assign mem_instr = 1'b0;

  // mem_wdata doubles as the data register: it holds the word read in RD, or the
  // fill pattern for the whole job in fill mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_COPY;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= WSTRB_NONE;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            src_q  <= word_align(src_addr);
            dst_q  <= word_align(dst_addr);
            cnt_q  <= word_count;
            mode_q <= mode;
            if (word_count == '0) begin
              state_q <= FIN;
            end else if (mode == MODE_FILL) begin
              state_q   <= WR;
              mem_valid <= 1'b1;
              mem_addr  <= word_align(dst_addr);
              mem_wdata <= fill_value;
              mem_wstrb <= WSTRB_WORD;
            end else begin
              state_q   <= RD;
              mem_valid <= 1'b1;
              mem_addr  <= word_align(src_addr);
              mem_wstrb <= WSTRB_NONE;
            end
          end
        end
        RD: begin
          if (mem_ready) begin
            src_q     <= src_nxt;
            mem_wdata <= mem_rdata;
            mem_addr  <= dst_q;
            mem_wstrb <= WSTRB_WORD;
            state_q   <= WR;
          end
        end
        WR: begin
          if (mem_ready) begin
            dst_q <= dst_nxt;
            cnt_q <= cnt_q - LEN_W'(1);
            if (last_word) begin
              state_q   <= FIN;
              mem_valid <= 1'b0;
              mem_wstrb <= WSTRB_NONE;
            end else if (mode_q == MODE_FILL) begin
              mem_addr <= dst_nxt;
            end else begin
              // src_q was already advanced when the read completed.
              state_q   <= RD;
              mem_addr  <= src_q;
              mem_wstrb <= WSTRB_NONE;
            end
          end
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: block-RAM responder with optional stalls, word-level reference model.
module tb_mem_dma;

  localparam int LOGN = 8192;

  typedef struct {
    logic        md;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] n;
    logic [31:0] fv;
    int          spur;
    bit          stall;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] fill_value = '0;
  logic        busy, done, mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        rdy = 1'b0;
  logic [31:0] rdata = '0;

  mem_dma #(.LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (rdy),
    .mem_rdata  (rdata)
  );

  always #5 clk = ~clk;

  // Memory: background contents plus words written by the engine (1024-word window).
  logic [31:0] init_mem [1024];
  logic [31:0] wr_mem   [1024];
  bit          wr_valid [1024];
  logic [31:0] ref_mem  [1024];

  logic [31:0] log_addr [LOGN];
  logic [3:0]  log_ws   [LOGN];
  logic [31:0] log_dat  [LOGN];
  int n_acc = 0;
  int n_rd = 0;
  int wcnt = 0;
  int rnd_need = 0;
  int need;
  bit stall_rand = 1'b0;
  int stall_rd_idx = -1;
  int done_cnt = 0;
  int stab_viol = 0;
  bit pend = 1'b0;
  logic [67:0] pend_v = '0;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] eff(input int i);
    return wr_valid[i] ? wr_mem[i] : init_mem[i];
  endfunction

  always_comb begin
    need = 0;
    if (stall_rand) need = rnd_need;
    else if (mem_wstrb == 4'h0 && n_rd == stall_rd_idx) need = 5;
  end

  // Responder: ready is a registered one-cycle pulse, ignoring valid during its ready cycle.
  always @(posedge clk) begin
    if (reset) begin
      rdy  <= 1'b0;
      wcnt <= 0;
    end else if (rdy) begin
      rdy <= 1'b0;
    end else if (mem_valid) begin
      if (wcnt < need) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt     <= 0;
        rdy      <= 1'b1;
        rnd_need <= int'($urandom_range(0, 3));
        log_addr[n_acc % LOGN] <= mem_addr;
        log_ws[n_acc % LOGN]   <= mem_wstrb;
        if (mem_wstrb != 4'h0) begin
          log_dat[n_acc % LOGN]   <= mem_wdata;
          wr_mem[mem_addr[11:2]]   <= mem_wdata;
          wr_valid[mem_addr[11:2]] <= 1'b1;
        end else begin
          log_dat[n_acc % LOGN] <= 32'h0;
          rdata <= eff(int'(mem_addr[11:2]));
          n_rd  <= n_rd + 1;
        end
        n_acc <= n_acc + 1;
      end
    end
  end

  // A pending request (valid, not yet acknowledged) must hold address, strobe and data.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (mem_valid === 1'b1 && pend && {mem_addr, mem_wstrb, mem_wdata} !== pend_v)
      stab_viol <= stab_viol + 1;
    pend   <= (mem_valid === 1'b1) && !rdy && !reset;
    pend_v <= {mem_addr, mem_wstrb, mem_wdata};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic mem_check(input string nm);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 1024; i++) begin
      if (eff(i) !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0) $display("word index %0d: got %h, model %h", first, eff(first), ref_mem[first]);
    chk(nm, bad, 0);
  endtask

  task automatic run_job(input string nm, input vec_t v);
    logic [31:0] ea[$];
    logic [3:0]  ews[$];
    logic [31:0] ed[$];
    logic [31:0] s, t, d;
    int lat, acc0, dn0, m;
    // Reference: word i is read from src+4i then written to dst+4i, in order.
    for (int i = 0; i < int'(v.n); i++) begin
      s = (v.src & 32'hFFFF_FFFC) + 32'(4 * i);
      t = (v.dst & 32'hFFFF_FFFC) + 32'(4 * i);
      if (v.md) begin
        d = v.fv;
      end else begin
        d = ref_mem[s[11:2]];
        ea.push_back(s); ews.push_back(4'h0); ed.push_back(32'h0);
      end
      ref_mem[t[11:2]] = d;
      ea.push_back(t); ews.push_back(4'hF); ed.push_back(d);
    end
    acc0 = n_acc;
    dn0  = done_cnt;
    if (v.stall) stall_rd_idx = n_rd + 1;
    start = 1'b1; mode = v.md; src_addr = v.src; dst_addr = v.dst;
    word_count = v.n; fill_value = v.fv;
    @(posedge clk); #1;
    start = 1'b0; mode = ~v.md; src_addr = $urandom; dst_addr = $urandom;
    word_count = 16'($urandom); fill_value = $urandom;
    chk({nm, ".busy_rise"}, busy, 1);
    chk({nm, ".valid_rise"}, mem_valid, (v.n != 0));
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      if (v.spur != 0 && lat == v.spur) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk({nm, ".done_seen"}, done, 1);
    if (v.exp_lat >= 0) chk({nm, ".latency"}, lat, v.exp_lat);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, ".done_once"}, done_cnt - dn0, 1);
    chk({nm, ".busy_idle"}, busy, 0);
    chk({nm, ".valid_idle"}, mem_valid, 0);
    chk({nm, ".acc_count"}, n_acc - acc0, ea.size());
    m = (n_acc - acc0 < ea.size()) ? n_acc - acc0 : ea.size();
    for (int i = 0; i < m; i++) begin
      chk({nm, ".acc_addr"}, log_addr[(acc0 + i) % LOGN], ea[i]);
      chk({nm, ".acc_wstrb"}, log_ws[(acc0 + i) % LOGN], ews[i]);
      if (ews[i] != 4'h0) chk({nm, ".acc_wdata"}, log_dat[(acc0 + i) % LOGN], ed[i]);
    end
    mem_check({nm, ".mem"});
    chk({nm, ".stable"}, stab_viol, 0);
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    int acc0, dn0, k;
    for (int i = 0; i < 1024; i++) init_mem[i] = $urandom;
    init_mem[10'h040] = 32'h1111_1111;
    init_mem[10'h041] = 32'h2222_2222;
    init_mem[10'h042] = 32'h3333_3333;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_mem[i];

    //          md    src            dst            n      fill           spur stall lat
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0000_0200, 16'd3, 32'h0,         0, 1'b0, 13};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0400, 16'd4, 32'hD8B7_D8B7, 0, 1'b0, 9};
    vecs[2] = '{1'b0, 32'h0000_0100, 32'h0000_0500, 16'd0, 32'h0,         0, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h0000_0100, 32'h0000_0300, 16'd3, 32'h0,         0, 1'b1, 18};
    vecs[4] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF8, 16'd3, 32'hCAFE_F00D, 2, 1'b0, 7};
    vecs[5] = '{1'b0, 32'h0000_0107, 32'h0000_0601, 16'd1, 32'h0,         0, 1'b0, 5};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_07FE, 16'd1, 32'h5A5A_A5A5, 0, 1'b0, 3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", mem_valid, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.wstrb", mem_wstrb, 0);
    chk("rst.instr", mem_instr, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle.busy", busy, 0);

    for (int i = 0; i < 7; i++) run_job($sformatf("vec%0d", i), vecs[i]);

    // Reset during the write of word 2 of a 5-word copy: only word 1 lands.
    ref_mem[10'h200] = ref_mem[10'h040];
    acc0 = n_acc;
    dn0  = done_cnt;
    start = 1'b1; mode = 1'b0; src_addr = 32'h100; dst_addr = 32'h800; word_count = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(n_acc - acc0 >= 3 && mem_valid === 1'b1 && mem_wstrb == 4'hF && !rdy) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rstjob.reach_wr2", n_acc - acc0, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstjob.valid", mem_valid, 0);
    chk("rstjob.busy", busy, 0);
    chk("rstjob.wstrb", mem_wstrb, 0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rstjob.no_done", done_cnt - dn0, 0);
    chk("rstjob.acc", n_acc - acc0, 3);
    mem_check("rstjob.mem");
    run_job("after_rst", vecs[0]);

    for (int r = 0; r < 30; r++) begin
      stall_rand = r[0];
      rv.md  = 1'($urandom_range(0, 1));
      rv.src = $urandom;
      rv.dst = $urandom;
      rv.n   = 16'($urandom_range(0, 12));
      rv.fv  = $urandom;
      rv.spur  = (rv.n != 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
      rv.stall = 1'b0;
      if (stall_rand) rv.exp_lat = -1;
      else if (rv.n == 0) rv.exp_lat = 1;
      else rv.exp_lat = rv.md ? 2 * int'(rv.n) + 1 : 4 * int'(rv.n) + 1;
      run_job($sformatf("rand%0d", r), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
